// File: rtl/plms_weight_update.sv
// Complex LMS weight-update stage: serial MAC of y = sum conj(w_k)*x_k, error e = d - y,
// then a serial weight update w_k += mu * x_k * conj(e), one tap per cycle.
module plms_weight_update #(
    parameter int unsigned N_TAPS   = 4,
    parameter int unsigned MU_SHIFT = 4,
    parameter int unsigned ACC_W    = 44
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] x_I,
    input  logic [17:0] x_Q,
    input  logic [17:0] d_I,
    input  logic [17:0] d_Q,
    input  logic        adapt_en,
    output logic        out_valid,
    output logic [17:0] y_I,
    output logic [17:0] y_Q,
    output logic [17:0] e_I,
    output logic [17:0] e_Q,
    input  logic [3:0]  w_rd_idx,
    output logic [17:0] w_rd_I,
    output logic [17:0] w_rd_Q
);

    localparam int unsigned KW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(N_TAPS - 1);

    typedef enum logic [1:0] {StIdle, StMac, StErr, StUpd} state_e;
    state_e state_q, state_d;

    logic signed [17:0]      xi_q [N_TAPS];
    logic signed [17:0]      xq_q [N_TAPS];
    logic signed [17:0]      wi_q [N_TAPS];
    logic signed [17:0]      wq_q [N_TAPS];
    logic signed [17:0]      di_q, dq_q;
    logic                    adapt_q;
    logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
    logic [KW-1:0]           k_q;
    logic signed [17:0]      y_i_q, y_q_q, e_i_q, e_q_q;
    logic                    out_valid_q;

    function automatic logic signed [17:0] sat18(input logic signed [63:0] v);
        if (v > 64'sd131071) begin
            return 18'h1FFFF;
        end else if (v < -64'sd131072) begin
            return 18'h20000;
        end else begin
            return v[17:0];
        end
    endfunction

    // One multiplier set serves both phases: the coefficient is w_k in MAC and e in UPD,
    // and the conj() placement makes the two sums identical in form.
    logic signed [17:0] tap_xi, tap_xq, ci, cq;
    logic signed [35:0] p0, p1, p2, p3;
    logic signed [63:0] sum_re, sum_im;

    always_comb begin
        tap_xi = xi_q[k_q];
        tap_xq = xq_q[k_q];
        ci     = (state_q == StUpd) ? e_i_q : wi_q[k_q];
        cq     = (state_q == StUpd) ? e_q_q : wq_q[k_q];
        p0     = ci * tap_xi;
        p1     = cq * tap_xq;
        p2     = ci * tap_xq;
        p3     = cq * tap_xi;
        sum_re = 64'(p0) + 64'(p1);
        sum_im = 64'(p2) - 64'(p3);
    end

    logic signed [17:0] y_i_c, y_q_c, e_i_c, e_q_c, w_i_new, w_q_new;

    always_comb begin
        y_i_c   = sat18(64'(acc_i_q) >>> 17);
        y_q_c   = sat18(64'(acc_q_q) >>> 17);
        e_i_c   = sat18(64'(di_q) - 64'(y_i_c));
        e_q_c   = sat18(64'(dq_q) - 64'(y_q_c));
        w_i_new = sat18(64'(wi_q[k_q]) + (sum_re >>> (17 + MU_SHIFT)));
        w_q_new = sat18(64'(wq_q[k_q]) + (sum_im >>> (17 + MU_SHIFT)));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StMac;
            StMac:   if (k_q == KLAST) state_d = StErr;
            StErr:   state_d = StUpd;
            StUpd:   if (k_q == KLAST) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                xi_q[i] <= '0;
                xq_q[i] <= '0;
                wi_q[i] <= (i == 0) ? 18'h1FFFF : 18'h00000;
                wq_q[i] <= '0;
            end
            di_q        <= '0;
            dq_q        <= '0;
            adapt_q     <= 1'b0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            k_q         <= '0;
            y_i_q       <= '0;
            y_q_q       <= '0;
            e_i_q       <= '0;
            e_q_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        for (int i = 1; i < N_TAPS; i++) begin
                            xi_q[i] <= xi_q[i-1];
                            xq_q[i] <= xq_q[i-1];
                        end
                        xi_q[0] <= x_I;
                        xq_q[0] <= x_Q;
                        di_q    <= d_I;
                        dq_q    <= d_Q;
                        adapt_q <= adapt_en;
                        acc_i_q <= '0;
                        acc_q_q <= '0;
                        k_q     <= '0;
                    end
                end
                StMac: begin
                    acc_i_q <= acc_i_q + ACC_W'(sum_re);
                    acc_q_q <= acc_q_q + ACC_W'(sum_im);
                    k_q     <= (k_q == KLAST) ? '0 : k_q + 1'b1;
                end
                StErr: begin
                    y_i_q       <= y_i_c;
                    y_q_q       <= y_q_c;
                    e_i_q       <= e_i_c;
                    e_q_q       <= e_q_c;
                    out_valid_q <= 1'b1;
                    k_q         <= '0;
                end
                StUpd: begin
                    if (adapt_q) begin
                        wi_q[k_q] <= w_i_new;
                        wq_q[k_q] <= w_q_new;
                    end
                    k_q <= (k_q == KLAST) ? '0 : k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Indices at or beyond N_TAPS read back as zero.
    always_comb begin
        w_rd_I = '0;
        w_rd_Q = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (w_rd_idx == 4'(i)) begin
                w_rd_I = wi_q[i];
                w_rd_Q = wq_q[i];
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign y_I       = y_i_q;
    assign y_Q       = y_q_q;
    assign e_I       = e_i_q;
    assign e_Q       = e_q_q;

endmodule

// File: tb/tb_plms_weight_update.sv
// Scoreboard bench for plms_weight_update: directed samples push expected y/e, a negedge
// monitor pops and compares on every out_valid pulse.
module tb_plms_weight_update;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        adapt_en = 1'b0;
    logic [17:0] x_I = '0, x_Q = '0, d_I = '0, d_Q = '0;
    logic [3:0]  w_rd_idx = '0;
    logic        in_ready, out_valid;
    logic [17:0] y_I, y_Q, e_I, e_Q, w_rd_I, w_rd_Q;

    plms_weight_update #(.N_TAPS(N), .MU_SHIFT(4), .ACC_W(44)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_I      (x_I),
        .x_Q      (x_Q),
        .d_I      (d_I),
        .d_Q      (d_Q),
        .adapt_en (adapt_en),
        .out_valid(out_valid),
        .y_I      (y_I),
        .y_Q      (y_Q),
        .e_I      (e_I),
        .e_Q      (e_Q),
        .w_rd_idx (w_rd_idx),
        .w_rd_I   (w_rd_I),
        .w_rd_Q   (w_rd_Q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    typedef struct packed {
        logic [17:0] yi;
        logic [17:0] yq;
        logic [17:0] ei;
        logic [17:0] eq;
    } exp_t;
    exp_t sb[$];
    exp_t ex;

    function automatic int s18(input logic [17:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int yi, input int yq, input int ei, input int eq);
        exp_t t;
        t.yi = 18'(yi);
        t.yq = 18'(yq);
        t.ei = 18'(ei);
        t.eq = 18'(eq);
        sb.push_back(t);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            pulse_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid: got pulse want none");
            end else begin
                ex = sb.pop_front();
                chk("y_I", s18(y_I), s18(ex.yi));
                chk("y_Q", s18(y_Q), s18(ex.yq));
                chk("e_I", s18(e_I), s18(ex.ei));
                chk("e_Q", s18(e_Q), s18(ex.eq));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_w(input string tag, input int idx, input int wi, input int wq);
        w_rd_idx = 4'(idx);
        #1;
        chk({tag, "_wI"}, s18(w_rd_I), wi);
        chk({tag, "_wQ"}, s18(w_rd_Q), wq);
    endtask

    // Accept at edge 0, pulse after edge N+1, idle again after edge 2N+1.
    task automatic run_sample(input int xi, input int xq, input int di, input int dq,
                              input bit ad, input string tag);
        chk({tag, "_ready_pre"}, int'(in_ready), 1);
        x_I = 18'(xi);
        x_Q = 18'(xq);
        d_I = 18'(di);
        d_Q = 18'(dq);
        adapt_en = ad;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_ready_low"}, int'(in_ready), 0);
        repeat (N) step();
        chk({tag, "_ov_early"}, int'(out_valid), 0);
        step();
        chk({tag, "_ov_pulse"}, int'(out_valid), 1);
        repeat (N) step();
        chk({tag, "_ready_back"}, int'(in_ready), 1);
        chk({tag, "_ov_low"}, int'(out_valid), 0);
    endtask

    int acc_edges[$];
    int low_cnt;
    int p0;
    bit acc_now;

    initial begin
        do_reset();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y_I", s18(y_I), 0);
        chk("rst_e_I", s18(e_I), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        check_w("rst0", 0, 131071, 0);
        check_w("rst1", 1, 0, 0);
        check_w("rst2", 2, 0, 0);
        check_w("rst3", 3, 0, 0);
        check_w("rst7", 7, 0, 0);

        push_exp(65535, 0, -65535, 0);
        run_sample(65536, 0, 0, 0, 1'b1, "basic");
        check_w("basic0", 0, 129023, 0);
        check_w("basic1", 1, 0, 0);
        check_w("basic3", 3, 0, 0);

        do_reset();
        push_exp(65535, 0, -65535, 0);
        run_sample(65536, 0, 0, 0, 1'b0, "frozen");
        check_w("frozen0", 0, 131071, 0);
        check_w("frozen1", 1, 0, 0);

        do_reset();
        push_exp(131070, 0, -131072, 0);
        run_sample(131071, 0, -131072, 0, 1'b1, "sat");
        check_w("sat0", 0, 122879, 0);
        chk("sat_y_held", s18(y_I), 131070);

        // Continuous in_valid: one accept every 2N+2 edges, weights adapting each time.
        do_reset();
        push_exp(65535, 0, -65535, 0);
        push_exp(64511, 0, -64511, 0);
        push_exp(62495, 0, -62495, 0);
        push_exp(59566, 0, -59566, 0);
        p0 = pulse_cnt;
        low_cnt = 0;
        x_I = 18'(65536);
        x_Q = '0;
        d_I = '0;
        d_Q = '0;
        adapt_en = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            acc_now = in_ready;
            step();
            if (acc_now) acc_edges.push_back(c);
            if (!in_ready) low_cnt++;
        end
        in_valid = 1'b0;
        chk("stream_accepts", acc_edges.size(), 4);
        for (int i = 0; i < acc_edges.size() && i < 4; i++) begin
            chk("stream_accept_edge", acc_edges[i], 10 * i);
        end
        chk("stream_ready_low", low_cnt, 36);
        chk("stream_pulses", pulse_cnt - p0, 4);
        check_w("stream0", 0, 123192, 0);
        check_w("stream1", 1, -5831, 0);
        check_w("stream2", 2, -3815, 0);
        check_w("stream3", 3, -1862, 0);

        // Reset during MAC aborts the sample; the next one runs from a clean state.
        do_reset();
        p0 = pulse_cnt;
        x_I = 18'(65536);
        d_I = '0;
        adapt_en = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check_w("abort0", 0, 131071, 0);
        check_w("abort1", 1, 0, 0);
        push_exp(65535, 0, -65535, 0);
        run_sample(65536, 0, 0, 0, 1'b1, "after_abort");
        chk("abort_pulses", pulse_cnt - p0, 1);
        check_w("after_abort0", 0, 129023, 0);
        check_w("after_abort1", 1, 0, 0);

        step();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/plms_weight_update.md
Name: plms_weight_update

Overview:
- Complex LMS adaptive-filter stage directly downstream of the delayed PLMS input stage. Consumes its 18-bit signed I/Q output.
- Holds a tap delay line and a complex weight vector. Computes the filter output y = sum conj(w_k)·x_k serially, one complex MAC per cycle.
- Forms the error e = d − y and updates the weights with w_k += mu·x_k·conj(e).
- y, e and the weights feed the beamformer output and monitor logic.

Parameters:
- N_TAPS, 4: number of complex taps; range 1..16.
- MU_SHIFT, 4: step size mu = 2^-MU_SHIFT; range 0..15.
- ACC_W, 44: MAC accumulator width; must be ≥ 37 + clog2(N_TAPS).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  sample strobe from upstream.
- in_ready  out  1  high only in IDLE.
- x_I, x_Q  in  18  signed Q1.17 input sample (upstream I, Q).
- d_I, d_Q  in  18  signed Q1.17 desired/reference; sampled with x.
- adapt_en  in  1  sampled at accept; 0 = freeze weights for this sample.
- out_valid  out  1  one-cycle pulse; y and e are valid.
- y_I, y_Q  out  18  signed Q1.17 filter output, held until next pulse.
- e_I, e_Q  out  18  signed Q1.17 error, held until next pulse.
- w_rd_idx  in  4  tap index for weight readback.
- w_rd_I, w_rd_Q  out  18  combinational readback of weight[w_rd_idx]. Returns 0 if idx ≥ N_TAPS.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-low on rst_n. rst_n=0 at a rising edge forces all of the following:
  - state=IDLE, in_ready=1 after release;
  - out_valid, y_*, e_*=0;
  - delay line = 0;
  - weight[0]=(131071,0); all other weights = 0.
- Reset overrides any in-flight operation. A sample interrupted by reset never produces out_valid and never modifies weights.
- FSM states: IDLE, MAC, ERR, UPD.
  - IDLE: on edge with in_valid=1:
    - shift x into delay line (x_0 = newest, x_{N-1} dropped);
    - latch d and adapt_en;
    - clear the accumulators;
    - go to MAC with k=0.
    - in_valid=0 in IDLE: no state change.
  - MAC: one tap per cycle, for k = 0..N_TAPS-1:
    - accI += wI·xI + wQ·xQ;
    - accQ += wI·xQ − wQ·xI;
    - after tap N_TAPS-1, go to ERR.
  - ERR: one cycle.
    - y = sat18(acc >>> 17).
    - e = sat18(d − y), computed at 19 bits then saturated.
    - Register y_*, e_*; out_valid=1 for exactly this edge's following cycle; go to UPD with k=0.
  - UPD: one tap per cycle, k = 0..N_TAPS-1:
    - if the latched adapt_en=1:
      - wI += (xI·eI + xQ·eQ) >>> (17+MU_SHIFT);
      - wQ += (xQ·eI − xI·eQ) >>> (17+MU_SHIFT);
      - each result saturated to 18 bits.
    - if adapt_en=0, weights are unchanged.
    - after tap N_TAPS-1, go to IDLE.
- Timing: with the accepting edge numbered 0:
  - out_valid is high after edge N_TAPS+1;
  - the last weight write is at edge 2·N_TAPS+1;
  - in_ready is high again after that edge.
  - Next accept is at edge 2·N_TAPS+2 at the earliest. Throughput is 1 sample per 2·N_TAPS+2 cycles.
- in_valid while in_ready=0 is ignored. No buffering; upstream must hold or drop the sample.
- Arithmetic:
  - products are 36-bit signed;
  - all shifts are arithmetic (floor), with no rounding;
  - sat18 clamps to [−131072, 131071];
  - the accumulator never wraps for legal parameters.
- Weight readback reflects committed weights. A weight updated at edge n is visible after edge n.

Test Plan:
- Reset, N_TAPS=4 → out_valid=0, y=e=0, in_ready=1; readback idx0 = (131071,0), idx1..3 = (0,0), idx 7 = (0,0).
- MU_SHIFT=4, adapt_en=1, x=(65536,0), d=(0,0) from reset:
  - out_valid pulses after edge 5 with y=(65535,0), e=(−65535,0);
  - after edge 9, w0=(129023,0), w1..3 unchanged at 0;
  - in_ready=1 after edge 9.
- in_valid held high for 40 cycles → exactly 4 samples accepted, at edges 0, 10, 20, 30. in_ready low for 9 cycles after each accept. out_valid pulses 4 times.
- x=(131071,0), d=(−131072,0) from reset → y=(131070,0), e saturates to (−131072,0). w0 update stays within range with no wrap.
- Same stimulus as the second scenario but with adapt_en=0 → y and e as before; all weights still at reset values after edge 9.
- rst_n=0 at edge 3 during MAC, released at edge 5 → out_valid never pulses. Weights and delay line are at reset values. A new sample is accepted normally on the first edge after release.
